// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus.
// Exactly one agent drives at a time, every handover leaves the bus floating for
// TURN_CYCLES cycles, and MAX_HOLD bounds how long one agent may keep the bus.
// A grant from idle is issued one cycle after the request is sampled. Grants
// handed over straight from TURN take effect at once, so the float gap stays
// exactly TURN_CYCLES long.
module tri_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] drv_en,
    output logic [ID_W-1:0]  owner_id,
    output logic             bus_busy,
    output logic             turn,
    output logic             timeout_err
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [ID_W:0]     N_REQ_W   = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT_0 = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // First requesting agent at or after ptr, wrapping past the last agent.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [ID_W-1:0]    off;
        logic [ID_W:0]      sum;
        dbl = {r, r};
        rot = N_REQ'(dbl >> ptr);
        off = {ID_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k[ID_W-1:0];
            end else begin
                off = off;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        sum = (sum >= N_REQ_W) ? (sum - N_REQ_W) : sum;
        return sum[ID_W-1:0];
    endfunction

    // Rotation pointer after granting agent i: the agent just granted goes to the back.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
        return (i == LAST_ID) ? {ID_W{1'b0}} : (i + ID_W'(1));
    endfunction

    state_t             state_r, state_s;
    logic [ID_W-1:0]    rr_ptr_r, rr_ptr_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic [TURN_W-1:0]  turn_cnt_r, turn_cnt_s;
    logic               pend_r, pend_s;
    logic [ID_W-1:0]    pend_id_r, pend_id_s;
    logic [ID_W-1:0]    owner_s;
    logic               timeout_s;
    logic [ID_W-1:0]    pick_s;
    logic [N_REQ-1:0]   gnt_r, gnt_s;
    logic [N_REQ-1:0]   drv_en_r;
    logic [ID_W-1:0]    owner_id_r, owner_id_s;
    logic               bus_busy_r, bus_busy_s;
    logic               turn_r, turn_s;
    logic               timeout_err_r;

    // Next state, counters and the registered output values derived from the next state.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        turn_cnt_s = turn_cnt_r;
        pend_s     = pend_r;
        pend_id_s  = pend_id_r;
        owner_s    = owner_id_r;
        timeout_s  = 1'b0;
        pick_s     = rr_pick(req, rr_ptr_r);

        case (state_r)
            ST_IDLE: begin
                if (pend_r) begin
                    state_s    = ST_OWN;
                    owner_s    = pend_id_r;
                    rr_ptr_s   = next_ptr(pend_id_r);
                    hold_cnt_s = HOLD_ONE;
                    pend_s     = 1'b0;
                end else if (|req) begin
                    pend_s    = 1'b1;
                    pend_id_s = pick_s;
                end else begin
                    pend_s = 1'b0;
                end
            end
            ST_OWN: begin
                // A release wins over a timeout landing on the same edge.
                if (!req[owner_id_r]) begin
                    state_s    = ST_TURN;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    turn_cnt_s = TURN_ONE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = ST_TURN;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    turn_cnt_s = TURN_ONE;
                    timeout_s  = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_TURN: begin
                if (turn_cnt_r == TURN_LAST) begin
                    turn_cnt_s = {TURN_W{1'b0}};
                    if (|req) begin
                        state_s    = ST_OWN;
                        owner_s    = pick_s;
                        rr_ptr_s   = next_ptr(pick_s);
                        hold_cnt_s = HOLD_ONE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    turn_cnt_s = turn_cnt_r + TURN_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = {HOLD_W{1'b0}};
                turn_cnt_s = {TURN_W{1'b0}};
                pend_s     = 1'b0;
            end
        endcase

        gnt_s      = (state_s == ST_OWN) ? (ONE_HOT_0 << owner_s) : {N_REQ{1'b0}};
        owner_id_s = (state_s == ST_OWN) ? owner_s : {ID_W{1'b0}};
        bus_busy_s = (state_s == ST_OWN);
        turn_s     = (state_s == ST_TURN);
    end

    // State, counters and outputs; reset floats the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= {ID_W{1'b0}};
            hold_cnt_r    <= {HOLD_W{1'b0}};
            turn_cnt_r    <= {TURN_W{1'b0}};
            pend_r        <= 1'b0;
            pend_id_r     <= {ID_W{1'b0}};
            gnt_r         <= {N_REQ{1'b0}};
            drv_en_r      <= {N_REQ{1'b0}};
            owner_id_r    <= {ID_W{1'b0}};
            bus_busy_r    <= 1'b0;
            turn_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            hold_cnt_r    <= hold_cnt_s;
            turn_cnt_r    <= turn_cnt_s;
            pend_r        <= pend_s;
            pend_id_r     <= pend_id_s;
            gnt_r         <= gnt_s;
            drv_en_r      <= gnt_s;
            owner_id_r    <= owner_id_s;
            bus_busy_r    <= bus_busy_s;
            turn_r        <= turn_s;
            timeout_err_r <= timeout_s;
        end
    end

    assign gnt         = gnt_r;
    assign drv_en      = drv_en_r;
    assign owner_id    = owner_id_r;
    assign bus_busy    = bus_busy_r;
    assign turn        = turn_r;
    assign timeout_err = timeout_err_r;

endmodule
